// File: rtl/vending_credit_engine.sv
// Credit/dispense engine: accepts coins, serves selections and returns change greedily, one coin per cycle.
// Define VM_AUTO_TIMEOUT_EN to enable the idle auto-return timer.
module vending_credit_engine #(
  parameter int NUM_COINS   = 3,
  parameter int NUM_ITEMS   = 4,
  parameter int TOTAL_BITS  = 31,
  parameter int WAIT_CYCLES = 100
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_COINS-1:0]            i_input_coin,
  input  logic [NUM_ITEMS-1:0]            i_select_item,
  input  logic                            i_trigger_return,
  input  logic [NUM_ITEMS*TOTAL_BITS-1:0] i_item_price,
  input  logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_value,
  output logic [NUM_ITEMS-1:0]            o_available_item,
  output logic [NUM_ITEMS-1:0]            o_output_item,
  output logic [NUM_COINS-1:0]            o_return_coin,
  output logic                            o_coin_reject,
  output logic                            o_busy,
  output logic [TOTAL_BITS-1:0]           o_credit,
  output logic [TOTAL_BITS-1:0]           o_input_total,
  output logic [TOTAL_BITS-1:0]           o_output_total,
  output logic [TOTAL_BITS-1:0]           o_return_total
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_RETURN = 2'd2;
  // Wide enough that credit plus every coin at once cannot wrap.
  localparam int SUM_W = TOTAL_BITS + $clog2(NUM_COINS + 1);
  localparam logic [SUM_W-1:0] W_MAX = SUM_W'({TOTAL_BITS{1'b1}});

  logic [1:0]            r_state;
  logic [TOTAL_BITS-1:0] r_credit;
  logic [TOTAL_BITS-1:0] r_input_total;
  logic [TOTAL_BITS-1:0] r_output_total;
  logic [TOTAL_BITS-1:0] r_return_total;
  logic [NUM_ITEMS-1:0]  r_output_item;
  logic [NUM_COINS-1:0]  r_return_coin;
  logic                  r_coin_reject;

  logic [SUM_W-1:0]      w_coin_sum;
  logic                  w_coin_fits;
  logic [NUM_ITEMS-1:0]  w_sel_onehot;
  logic [TOTAL_BITS-1:0] w_sel_price;
  logic                  w_sel_ok;
  logic [NUM_COINS-1:0]  w_ret_onehot;
  logic [TOTAL_BITS-1:0] w_ret_value;
  logic                  w_ret_valid;
  logic                  w_coin_ok;
  logic                  w_dispense;
  logic                  w_tick;
  logic                  w_ret_done;
  logic                  w_timeout;
  logic [NUM_ITEMS-1:0]  w_avail;

  always_comb begin
    w_coin_sum = '0;
    for (int c = 0; c < NUM_COINS; c++) begin
      w_coin_sum = w_coin_sum +
        (i_input_coin[c] ? SUM_W'(i_coin_value[c*TOTAL_BITS +: TOTAL_BITS]) : SUM_W'(0));
    end
  end

  assign w_coin_fits  = (SUM_W'(r_credit) + w_coin_sum) <= W_MAX;
  assign w_sel_onehot = i_select_item & (~i_select_item + NUM_ITEMS'(1));

  always_comb begin
    w_sel_price = '0;
    w_avail     = '0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      w_sel_price = w_sel_price |
        (w_sel_onehot[k] ? i_item_price[k*TOTAL_BITS +: TOTAL_BITS] : {TOTAL_BITS{1'b0}});
      w_avail[k]  = (r_state == S_ACTIVE) && (r_credit >= i_item_price[k*TOTAL_BITS +: TOTAL_BITS]);
    end
  end

  // Coin values ascend, so the last affordable index is the largest returnable coin.
  always_comb begin
    w_ret_onehot = '0;
    w_ret_value  = '0;
    for (int j = 0; j < NUM_COINS; j++) begin
      w_ret_onehot = (i_coin_value[j*TOTAL_BITS +: TOTAL_BITS] <= r_credit) ?
                     (NUM_COINS'(1) << j) : w_ret_onehot;
      w_ret_value  = (i_coin_value[j*TOTAL_BITS +: TOTAL_BITS] <= r_credit) ?
                     i_coin_value[j*TOTAL_BITS +: TOTAL_BITS] : w_ret_value;
    end
  end

  assign w_sel_ok    = (|i_select_item) && (r_credit >= w_sel_price);
  assign w_ret_valid = |w_ret_onehot;
  assign w_coin_ok   = ((r_state == S_IDLE) || (r_state == S_ACTIVE)) && !i_trigger_return &&
                       (|i_input_coin) && w_coin_fits;
  assign w_dispense  = (r_state == S_ACTIVE) && !i_trigger_return && !(|i_input_coin) && w_sel_ok;
  assign w_tick      = (r_state == S_ACTIVE) && !i_trigger_return && !w_coin_ok && !w_dispense;
  assign w_ret_done  = (r_state == S_RETURN) && !w_ret_valid;

`ifdef VM_AUTO_TIMEOUT_EN
  localparam int TMR_W = $clog2(WAIT_CYCLES + 1);
  logic [TMR_W-1:0] r_timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= TMR_W'(WAIT_CYCLES);
    end else if (w_coin_ok || w_dispense || w_ret_done) begin
      r_timer <= TMR_W'(WAIT_CYCLES);
    end else if (w_tick) begin
      r_timer <= r_timer - TMR_W'(1);
    end else begin
      r_timer <= r_timer;
    end
  end

  assign w_timeout = w_tick && (r_timer == TMR_W'(1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_input_total  <= '0;
      r_output_total <= '0;
      r_return_total <= '0;
      r_output_item  <= '0;
      r_return_coin  <= '0;
      r_coin_reject  <= 1'b0;
    end else begin
      r_output_item <= '0;
      r_return_coin <= '0;
      r_coin_reject <= 1'b0;
      case (r_state)
        S_IDLE, S_ACTIVE: begin
          r_coin_reject <= (|i_input_coin) && (i_trigger_return || !w_coin_fits);
          if (i_trigger_return) begin
            r_state <= (r_state == S_ACTIVE) ? S_RETURN : S_IDLE;
          end else if (w_coin_ok) begin
            r_credit      <= r_credit + w_coin_sum[TOTAL_BITS-1:0];
            r_input_total <= r_input_total + w_coin_sum[TOTAL_BITS-1:0];
            r_state       <= S_ACTIVE;
          end else if (w_dispense) begin
            r_output_item  <= w_sel_onehot;
            r_credit       <= r_credit - w_sel_price;
            r_output_total <= r_output_total + w_sel_price;
            r_state        <= (r_credit == w_sel_price) ? S_IDLE : S_ACTIVE;
          end else if (w_timeout) begin
            r_state <= S_RETURN;
          end else begin
            r_state <= r_state;
          end
        end
        S_RETURN: begin
          r_coin_reject <= |i_input_coin;
          if (w_ret_valid) begin
            r_return_coin  <= w_ret_onehot;
            r_credit       <= r_credit - w_ret_value;
            r_return_total <= r_return_total + w_ret_value;
          end else begin
            r_credit <= '0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_credit <= '0;
        end
      endcase
    end
  end

  assign o_available_item = w_avail;
  assign o_output_item    = r_output_item;
  assign o_return_coin    = r_return_coin;
  assign o_coin_reject    = r_coin_reject;
  assign o_busy           = (r_state == S_RETURN);
  assign o_credit         = r_credit;
  assign o_input_total    = r_input_total;
  assign o_output_total   = r_output_total;
  assign o_return_total   = r_return_total;

endmodule

// File: tb/tb_vending_credit_engine.sv
// Randomised bench for vending_credit_engine against a transaction-level reference model.
module tb_vending_credit_engine;
  localparam int NC = 3, NI = 4, TBW = 31, WAITC = 100;
  localparam int M_IDLE = 0, M_ACTIVE = 1, M_RET = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NC-1:0] coin;
  logic [NI-1:0] sel;
  logic trig;
  logic [TBW-1:0] coin_val [NC];
  logic [TBW-1:0] price [NI];
  logic [NC*TBW-1:0] coin_bus;
  logic [NI*TBW-1:0] price_bus;
  logic [NI-1:0] o_available_item, o_output_item;
  logic [NC-1:0] o_return_coin;
  logic o_coin_reject, o_busy;
  logic [TBW-1:0] o_credit, o_input_total, o_output_total, o_return_total;

  assign coin_bus  = {coin_val[2], coin_val[1], coin_val[0]};
  assign price_bus = {price[3], price[2], price[1], price[0]};

  always #5 clk = ~clk;

  vending_credit_engine #(.NUM_COINS(NC), .NUM_ITEMS(NI), .TOTAL_BITS(TBW), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .reset(reset), .i_input_coin(coin), .i_select_item(sel),
    .i_trigger_return(trig), .i_item_price(price_bus), .i_coin_value(coin_bus),
    .o_available_item(o_available_item), .o_output_item(o_output_item),
    .o_return_coin(o_return_coin), .o_coin_reject(o_coin_reject), .o_busy(o_busy),
    .o_credit(o_credit), .o_input_total(o_input_total), .o_output_total(o_output_total),
    .o_return_total(o_return_total));

  int n_cmp = 0, n_bad = 0;
  int m_state, m_idle;
  longint m_credit;
  logic [TBW-1:0] m_in, m_out, m_ret;
  logic [NI-1:0] e_item;
  logic [NC-1:0] e_coin;
  logic e_rej;
  int plan[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Greedy change plan worked out up front for the whole return sequence.
  task automatic plan_return();
    longint c = m_credit;
    plan.delete();
    while (c >= longint'(coin_val[0])) begin
      for (int j = NC - 1; j >= 0; j--) begin
        if (longint'(coin_val[j]) <= c) begin
          plan.push_back(j);
          c -= longint'(coin_val[j]);
          break;
        end
      end
    end
  endtask

  task automatic idle_tick();
`ifdef VM_AUTO_TIMEOUT_EN
    m_idle++;
    if (m_idle >= WAITC) begin
      plan_return();
      m_state = M_RET;
    end
`endif
  endtask

  task automatic model_step();
    longint sum;
    int k, j;
    e_item = '0; e_coin = '0; e_rej = 1'b0;
    if (reset) begin
      m_state = M_IDLE; m_credit = 0; m_in = '0; m_out = '0; m_ret = '0; m_idle = 0;
      plan.delete();
    end else if (m_state == M_RET) begin
      e_rej = |coin;
      if (plan.size() > 0) begin
        j = plan.pop_front();
        e_coin[j] = 1'b1;
        m_credit -= longint'(coin_val[j]);
        m_ret = m_ret + coin_val[j];
      end else begin
        m_credit = 0; m_state = M_IDLE; m_idle = 0;
      end
    end else if (trig) begin
      e_rej = |coin;
      if (m_state == M_ACTIVE) begin
        plan_return();
        m_state = M_RET;
      end
    end else if (|coin) begin
      sum = 0;
      for (int c = 0; c < NC; c++) if (coin[c]) sum += longint'(coin_val[c]);
      if (m_credit + sum <= longint'(2147483647)) begin
        m_credit += sum; m_in = m_in + TBW'(sum); m_idle = 0; m_state = M_ACTIVE;
      end else begin
        e_rej = 1'b1;
        if (m_state == M_ACTIVE) idle_tick();
      end
    end else if (m_state == M_ACTIVE) begin
      k = -1;
      for (int i = NI - 1; i >= 0; i--) if (sel[i]) k = i;
      if (k >= 0 && m_credit >= longint'(price[k])) begin
        e_item[k] = 1'b1;
        m_credit -= longint'(price[k]);
        m_out = m_out + price[k];
        m_idle = 0;
        if (m_credit == 0) m_state = M_IDLE;
      end else begin
        idle_tick();
      end
    end
  endtask

  task automatic check_all();
    logic [NI-1:0] e_av;
    for (int k = 0; k < NI; k++) e_av[k] = (m_state == M_ACTIVE) && (m_credit >= longint'(price[k]));
    check_eq("credit", 64'(o_credit), 64'(m_credit));
    check_eq("available", 64'(o_available_item), 64'(e_av));
    check_eq("output_item", 64'(o_output_item), 64'(e_item));
    check_eq("return_coin", 64'(o_return_coin), 64'(e_coin));
    check_eq("coin_reject", 64'(o_coin_reject), 64'(e_rej));
    check_eq("busy", 64'(o_busy), 64'(m_state == M_RET));
    check_eq("input_total", 64'(o_input_total), 64'(m_in));
    check_eq("output_total", 64'(o_output_total), 64'(m_out));
    check_eq("return_total", 64'(o_return_total), 64'(m_ret));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    reset = 1'b0; coin = '0; sel = '0; trig = 1'b0;
  endtask

  initial begin
    coin_val[0] = 31'd100; coin_val[1] = 31'd500; coin_val[2] = 31'd1000;
    price[0] = 31'd400; price[1] = 31'd500; price[2] = 31'd1000; price[3] = 31'd2000;
    quiet();
    reset = 1'b1;
    @(negedge clk);
    cycle();
    check_eq("reset_credit", 64'(o_credit), 64'd0);
    check_eq("reset_busy", 64'(o_busy), 64'd0);

    quiet(); coin = 3'b110; cycle(); quiet();
    check_eq("t1_credit", 64'(o_credit), 64'd1500);
    check_eq("t1_in_total", 64'(o_input_total), 64'd1500);
    check_eq("t1_avail", 64'(o_available_item), 64'b0111);

    sel = 4'b0110; cycle(); quiet();
    check_eq("t2_item", 64'(o_output_item), 64'b0010);
    check_eq("t2_credit", 64'(o_credit), 64'd1000);
    check_eq("t2_out_total", 64'(o_output_total), 64'd500);

    coin = 3'b001; trig = 1'b1; cycle(); quiet();
    check_eq("t3_reject", 64'(o_coin_reject), 64'd1);
    check_eq("t3_busy", 64'(o_busy), 64'd1);
    cycle();
    check_eq("t3_ret_coin", 64'(o_return_coin), 64'b100);
    cycle();
    check_eq("t3_idle", 64'(o_busy), 64'd0);
    check_eq("t3_ret_total", 64'(o_return_total), 64'd1000);

    coin = 3'b011; cycle(); coin = 3'b001; cycle(); quiet();
    check_eq("t4_credit", 64'(o_credit), 64'd700);
    for (int i = 0; i < WAITC - 1; i++) cycle();
    check_eq("t4_not_yet", 64'(o_busy), 64'd0);
    cycle();
`ifdef VM_AUTO_TIMEOUT_EN
    check_eq("t4_timeout", 64'(o_busy), 64'd1);
    cycle(); check_eq("t4_ret500", 64'(o_return_coin), 64'b010);
    cycle(); check_eq("t4_ret100a", 64'(o_return_coin), 64'b001);
    cycle(); check_eq("t4_ret100b", 64'(o_return_coin), 64'b001);
    cycle();
`else
    check_eq("t4_held", 64'(o_credit), 64'd700);
    trig = 1'b1; cycle(); quiet();
    for (int i = 0; i < 4; i++) cycle();
`endif
    check_eq("t4_done_busy", 64'(o_busy), 64'd0);
    check_eq("t4_done_credit", 64'(o_credit), 64'd0);

    coin_val[2] = 31'd2147483548; coin = 3'b100; cycle();
    coin_val[2] = 31'd1000; cycle(); quiet();
    check_eq("t5_reject", 64'(o_coin_reject), 64'd1);
    check_eq("t5_credit", 64'(o_credit), 64'd2147483548);
    reset = 1'b1; cycle(); quiet();

    coin = 3'b111; cycle(); quiet();
    trig = 1'b1; cycle(); quiet();
    cycle();
    check_eq("t6_first_ret", 64'(o_return_coin), 64'b100);
    reset = 1'b1; cycle(); quiet();
    check_eq("t6_no_pulse", 64'(o_return_coin), 64'd0);
    check_eq("t6_credit", 64'(o_credit), 64'd0);
    check_eq("t6_ret_total", 64'(o_return_total), 64'd0);
    check_eq("t6_busy", 64'(o_busy), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      coin  = ($urandom_range(0, 99) < 30) ? NC'($urandom_range(1, 7)) : '0;
      sel   = ($urandom_range(0, 99) < 35) ? NI'($urandom_range(1, 15)) : '0;
      trig  = ($urandom_range(0, 99) < 4);
      reset = ($urandom_range(0, 299) == 0);
      cycle();
      if ($urandom_range(0, 249) == 0) begin
        quiet();
        for (int q = 0; q < WAITC + 10; q++) cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
